// File: rtl/alu_serial_seq_if.sv
// Operand/result bundle of the bit-serial ALU sequencer.
// The master drives the request and operands; the slave returns status and the result.
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one result bit per clock, LSB first, carry held in a flop.
// The result, cout and zero outputs only change on the edge that raises done.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_serial_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] res_sh_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;

  logic             bit_a;
  logic             bit_b;
  logic             f_bit;
  logic             carry_d;
  logic [WIDTH-1:0] res_full;
  logic             last_bit;

  assign bit_a    = a_sh_q[0];
  // Subtract uses the inverted B bit; the initial carry of 1 completes two's complement.
  assign bit_b    = (op_q == 3'b001) ? ~b_sh_q[0] : b_sh_q[0];
  assign res_full = {f_bit, res_sh_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    f_bit   = 1'b0;
    carry_d = carry_q;
    case (op_q)
      3'b000, 3'b001: begin
        f_bit   = bit_a ^ bit_b ^ carry_q;
        carry_d = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
      end
      3'b010:  f_bit = bit_a | b_sh_q[0];
      3'b011:  f_bit = bit_a | ~b_sh_q[0];
      3'b100:  f_bit = bit_a & b_sh_q[0];
      3'b101:  f_bit = bit_a & ~b_sh_q[0];
      3'b110:  f_bit = ~bit_a;
      default: f_bit = ~b_sh_q[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_full[WIDTH-1:1];
          carry_q  <= carry_d;
          if (last_bit) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_full;
            cout_q   <= (op_q[2:1] == 2'b00) ? carry_d : op_q[0];
            zero_q   <= (res_full == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= SHIFT;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            op_q    <= bus.op;
            cnt_q   <= '0;
            carry_q <= bus.op[0];
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq: vector table plus back-to-back and mid-op reset sequences.
module tb_alu_serial_seq;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   overlap;

  alu_serial_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.busy && bus.done) overlap++;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int bcnt, output logic got_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bcnt      = 0;
    got_done  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[13];

  initial begin
    int   bcnt;
    int   t;
    int   unstable;
    int   done_seen;
    logic got;

    checks  = 0;
    errors  = 0;
    overlap = 0;

    vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 8'hA5, 8'h0F, 8'hF5, 1'b1, 1'b0};
    vecs[5]  = '{3'b100, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
    vecs[6]  = '{3'b101, 8'hA5, 8'h0F, 8'hA0, 1'b1, 1'b0};
    vecs[7]  = '{3'b110, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 8'hA5, 8'h0F, 8'hF0, 1'b1, 1'b0};
    vecs[9]  = '{3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{3'b100, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   32'(bus.busy),   32'h0);
    chk("reset_done",   32'(bus.done),   32'h0);
    chk("reset_result", 32'(bus.result), 32'h0);
    chk("reset_cout",   32'(bus.cout),   32'h0);
    chk("reset_zero",   32'(bus.zero),   32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bcnt, got);
      $display("vec %0d: op=%b a=%h b=%h -> result=%h cout=%b zero=%b busy_cycles=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.result, bus.cout, bus.zero, bcnt);
      chk($sformatf("vec%0d_done", i),   32'(got),        32'h1);
      chk($sformatf("vec%0d_busy", i),   32'(bcnt),       32'(WIDTH));
      chk($sformatf("vec%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
      chk($sformatf("vec%0d_cout", i),   32'(bus.cout),   32'(vecs[i].cout));
      chk($sformatf("vec%0d_zero", i),   32'(bus.zero),   32'(vecs[i].zero));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i),  32'(bus.done),   32'h0);
    end

    // start held high with scrambled operands; second op accepted in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    unstable  = 0;
    got       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy && bus.result !== 8'h80) unstable++;
      bus.a  = 8'($urandom);
      bus.b  = 8'($urandom);
      bus.op = 3'($urandom);
    end
    $display("held-start op1: result=%h cout=%b zero=%b", bus.result, bus.cout, bus.zero);
    chk("hold_done1",   32'(got),        32'h1);
    chk("hold_result1", 32'(bus.result), 32'h30);
    chk("hold_stable1", 32'(unstable),   32'h0);
    bus.op = 3'b000;
    bus.a  = 8'h44;
    bus.b  = 8'h11;
    t      = 0;
    got    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t++;
      if (t == 1) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy && bus.result !== 8'h30) unstable++;
    end
    $display("back-to-back op2: result=%h gap=%0d", bus.result, t);
    chk("b2b_done2",   32'(got),        32'h1);
    chk("b2b_gap",     32'(t),          32'(WIDTH + 1));
    chk("b2b_result2", 32'(bus.result), 32'h55);
    chk("b2b_stable2", 32'(unstable),   32'h0);

    // reset asserted during the 4th SHIFT cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 8'h7F;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    $display("mid-shift reset: busy=%b done=%b result=%h cout=%b zero=%b",
             bus.busy, bus.done, bus.result, bus.cout, bus.zero);
    chk("midrst_busy",   32'(bus.busy),   32'h0);
    chk("midrst_done",   32'(bus.done),   32'h0);
    chk("midrst_result", 32'(bus.result), 32'h0);
    chk("midrst_cout",   32'(bus.cout),   32'h0);
    chk("midrst_zero",   32'(bus.zero),   32'h0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("midrst_no_done", 32'(done_seen), 32'h0);
    run_op(3'b001, 8'h50, 8'h20, bcnt, got);
    $display("post-reset op: result=%h cout=%b zero=%b busy_cycles=%0d", bus.result, bus.cout, bus.zero, bcnt);
    chk("postrst_done",   32'(got),        32'h1);
    chk("postrst_busy",   32'(bcnt),       32'(WIDTH));
    chk("postrst_result", 32'(bus.result), 32'h30);
    chk("postrst_cout",   32'(bus.cout),   32'h1);

    @(negedge clk);
    chk("busy_done_overlap", 32'(overlap), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
